// File: rtl/multdiv_seq.sv
// Sequencer for an iterative multiply/divide datapath: issues a one-cycle load,
// a run of step enables, then a one-cycle completion pulse (with divide-by-zero flag).
module multdiv_seq #(
  parameter int unsigned MULT_CYCLES = 16,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       div_zero,
  output logic       load,
  output logic       step_en,
  output logic [5:0] count,
  output logic       is_div,
  output logic       busy,
  output logic       data_resultRDY,
  output logic       data_exception
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       is_div_q, is_div_d;
  logic       exc_q, exc_d;

  logic       load_q, step_en_q, busy_q, rdy_q, exc_out_q;

  logic       start;
  logic [5:0] n_sel;

  assign start = ctrl_MULT | ctrl_DIV;
  assign n_sel = is_div_q ? DIV_N : MULT_N;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    exc_d    = exc_q;
    // A start request overrides whatever is in flight, including DONE.
    if (start) begin
      if (!ctrl_MULT && div_zero) begin
        state_d  = S_DONE;
        is_div_d = 1'b1;
        exc_d    = 1'b1;
      end else begin
        state_d  = S_LOAD;
        count_d  = '0;
        is_div_d = ~ctrl_MULT;
        exc_d    = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          state_d = S_RUN;
          count_d = '0;
        end
        S_RUN: begin
          count_d = count_q + 6'd1;
          if (count_q == n_sel - 6'd1) begin
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode, so they equal a
  // decode of the registered state while leaving no input-to-output path.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      exc_q     <= 1'b0;
      load_q    <= 1'b0;
      step_en_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      exc_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      exc_q     <= exc_d;
      load_q    <= (state_d == S_LOAD);
      step_en_q <= (state_d == S_RUN);
      busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
      rdy_q     <= (state_d == S_DONE);
      exc_out_q <= (state_d == S_DONE) && exc_d;
    end
  end

  assign load           = load_q;
  assign step_en        = step_en_q;
  assign busy           = busy_q;
  assign count          = count_q;
  assign is_div         = is_div_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_out_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: table of start scenarios with hand-computed
// per-cycle windows, plus hand-written reset and held-request sequences.
module tb_multdiv_seq;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ctrl_MULT = 1'b0;
  logic       ctrl_DIV = 1'b0;
  logic       div_zero = 1'b0;
  logic       load, step_en, is_div, busy, data_resultRDY, data_exception;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  multdiv_seq #(.MULT_CYCLES(16), .DIV_CYCLES(32)) dut (
    .clk           (clk),
    .clr           (clr),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .div_zero      (div_zero),
    .load          (load),
    .step_en       (step_en),
    .count         (count),
    .is_div        (is_div),
    .busy          (busy),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception)
  );

  always #5 clk = ~clk;

  // First start pulse at cycle 0, optional second at s1. Window 0/1 give the
  // expected LOAD cycle and RUN cycle range of each operation (empty: ra > rb).
  typedef struct {
    bit m0, d0, dz0;
    int s1;
    bit m1, d1, dz1;
    int ld0, ra0, rb0;
    bit iv0;
    int ld1, ra1, rb1;
    bit iv1;
    int rdy0, rdy1;
    bit exc;
    int nfin;
    int ncyc;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(bit m0, bit d0, bit dz0, int s1, bit m1, bit d1, bit dz1,
                              int ld0, int ra0, int rb0, bit iv0,
                              int ld1, int ra1, int rb1, bit iv1,
                              int rdy0, int rdy1, bit exc, int nfin, int ncyc);
    vec_t v;
    v.m0 = m0; v.d0 = d0; v.dz0 = dz0;
    v.s1 = s1; v.m1 = m1; v.d1 = d1; v.dz1 = dz1;
    v.ld0 = ld0; v.ra0 = ra0; v.rb0 = rb0; v.iv0 = iv0;
    v.ld1 = ld1; v.ra1 = ra1; v.rb1 = rb1; v.iv1 = iv1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.exc = exc; v.nfin = nfin; v.ncyc = ncyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {19'd0, load, step_en, busy, data_resultRDY, data_exception, is_div, count}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 clr = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; div_zero = 1'b0;
    #2 chk_all_zero("reset_state");
    @(posedge clk);
    #2 clr = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit rst);
    bit w0, w1, e_ld, e_st, e_rdy, e_exc;
    int ec, ei;
    if (rst) do_reset();
    for (int k = 0; k < v.ncyc; k++) begin
      @(negedge clk);
      w0    = (k >= v.ra0) && (k <= v.rb0);
      w1    = (k >= v.ra1) && (k <= v.rb1);
      e_ld  = (k == v.ld0) || (k == v.ld1);
      e_st  = w0 || w1;
      e_rdy = (k == v.rdy0) || (k == v.rdy1);
      e_exc = (k == v.rdy1) && v.exc;
      chk($sformatf("v%0d c%0d ld/st/busy/rdy/exc", idx, k),
          {27'd0, load, step_en, busy, data_resultRDY, data_exception},
          {27'd0, e_ld, e_st, e_ld | e_st, e_rdy, e_exc});
      ec = -1;
      if (k == 0 || e_ld) ec = 0;
      if (w0) ec = k - v.ra0;
      if (w1) ec = k - v.ra1;
      if (v.nfin >= 0 && k >= v.rdy1) ec = v.nfin;
      if (ec >= 0) chk($sformatf("v%0d c%0d count", idx, k), {26'd0, count}, ec);
      ei = -1;
      if (k == v.ld0 || w0) ei = v.iv0;
      if (k == v.ld1 || w1 || k >= v.rdy1) ei = v.iv1;
      if (ei >= 0) chk($sformatf("v%0d c%0d is_div", idx, k), {31'd0, is_div}, ei);
      #1;
      ctrl_MULT = (k == 0 && v.m0) || (k == v.s1 && v.m1);
      ctrl_DIV  = (k == 0 && v.d0) || (k == v.s1 && v.d1);
      div_zero  = (k == 0 && v.dz0) || (k == v.s1 && v.dz1);
    end
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; div_zero = 1'b0;
  endtask

  initial begin
    //           m d dz  s1 m d dz  ld0 ra0 rb0 iv0 ld1 ra1 rb1 iv1 rdy0 rdy1 exc nfin ncyc
    vecs[0] = mk(1,0,0, -1, 0,0,0, -1, -1, -2, 0,  1,  2, 17, 0,  -1,  18, 0,  16, 22);
    vecs[1] = mk(0,1,0, -1, 0,0,0, -1, -1, -2, 0,  1,  2, 33, 1,  -1,  34, 0,  32, 38);
    vecs[2] = mk(0,1,1, -1, 0,0,0, -1, -1, -2, 0, -1, -1, -2, 1,  -1,   1, 1,  -1,  5);
    vecs[3] = mk(1,1,1, -1, 0,0,0, -1, -1, -2, 0,  1,  2, 17, 0,  -1,  18, 0,  16, 22);
    vecs[4] = mk(1,0,0, 10, 0,1,0,  1,  2, 10, 0, 11, 12, 43, 1,  -1,  44, 0,  32, 48);
    vecs[5] = mk(1,0,0, 17, 1,0,0,  1,  2, 17, 0, 18, 19, 34, 0,  -1,  35, 0,  16, 38);
    vecs[6] = mk(1,0,0, 18, 0,1,0,  1,  2, 17, 0, 19, 20, 51, 1,  18,  52, 0,  32, 55);
    vecs[7] = mk(1,0,0, 18, 0,1,1,  1,  2, 17, 0, -1, -1, -2, 1,  18,  19, 1,  -1, 22);

    #2 chk_all_zero("power_on_reset");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i], 1'b1);

    // Asynchronous reset between edges while RUN is at count 7.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) chk("async pre count", {26'd0, count}, 32'd7);
      #1 ctrl_MULT = (k == 0);
    end
    ctrl_MULT = 1'b0;
    #1 clr = 1'b0;
    #1 chk_all_zero("async_clear_before_edge");
    @(posedge clk);
    #2 clr = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk($sformatf("post_clear c%0d busy/rdy", k), {30'd0, busy, data_resultRDY}, 32'd0);
    end
    run_vec(8, vecs[0], 1'b0);

    // Request held for 5 cycles keeps re-entering LOAD.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d load", k), {31'd0, load}, {31'd0, (k >= 1 && k <= 5)});
      chk($sformatf("hold c%0d rdy", k), {31'd0, data_resultRDY}, {31'd0, (k == 22)});
      if (k >= 1 && k <= 6) chk($sformatf("hold c%0d count", k), {26'd0, count}, 32'd0);
      #1 ctrl_MULT = (k <= 4);
    end
    ctrl_MULT = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter MULT_CYCLES, default 16, number of datapath step cycles per multiply; legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 32, number of datapath step cycles per divide; legal range 1..63.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ctrl_MULT  input  1  start-multiply request, sampled on each rising edge.
REQ-006 ctrl_DIV  input  1  start-divide request, sampled on each rising edge.
REQ-007 div_zero  input  1  divisor-is-zero flag, sampled only with an accepted ctrl_DIV.
REQ-008 load  output  1  datapath initialise strobe, high only in LOAD.
REQ-009 step_en  output  1  datapath step enable, high only in RUN.
REQ-010 count  output  6  current step index.
REQ-011 is_div  output  1  operation type latched at start (1 = divide).
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 data_resultRDY  output  1  one-cycle completion pulse, high only in DONE.
REQ-014 data_exception  output  1  divide-by-zero flag, valid and high only in DONE.

Function
REQ-015 Four states: IDLE, LOAD, RUN, DONE; all outputs decoded from registered state, count, is_div, and exc flag (Moore; no combinational input-to-output path).
REQ-016 Start = ctrl_MULT | ctrl_DIV sampled high in any state; if both high, multiply wins and is_div latches 0.
REQ-017 Start accepted with ctrl_DIV (ctrl_MULT low) and div_zero=1: next state DONE, exc flag set, is_div=1, no LOAD/RUN.
REQ-018 Any other accepted start: next state LOAD, count cleared to 0, exc flag cleared, is_div latched.
REQ-019 LOAD lasts exactly one cycle, then RUN with count=0.
REQ-020 RUN: count increments by 1 each cycle; when count = N-1 (N = DIV_CYCLES if is_div else MULT_CYCLES) and no start, next state DONE with count = N.
REQ-021 DONE lasts exactly one cycle, then IDLE; count holds N in DONE and in IDLE until the next start.
REQ-022 Latency: start high in cycle 0 -> LOAD cycle 1, RUN cycles 2..N+1, data_resultRDY high in cycle N+2 only.
REQ-023 Divide-by-zero latency: start in cycle 0 -> data_resultRDY and data_exception high in cycle 1 only.
REQ-024 Start during LOAD or RUN aborts the current operation with no data_resultRDY, and restarts per REQ-016..018.
REQ-025 Start during DONE: data_resultRDY still high that cycle; next state per REQ-017/018 (no IDLE cycle).
REQ-026 Start on the final RUN cycle (count = N-1): restart wins, no DONE for the aborted operation.
REQ-027 ctrl_* held high continuously restarts every cycle; the block never leaves LOAD (documented, not an error).
REQ-028 data_exception is low whenever data_resultRDY is low.

Reset
REQ-029 clr low forces immediately, independent of clk: state IDLE, count 0, is_div 0, exc flag 0; all outputs 0.
REQ-030 clr low mid-operation discards the operation; no data_resultRDY after release.
REQ-031 After clr rises, first start is accepted on the first rising edge with clr high.

Verification
REQ-032 Multiply, defaults: ctrl_MULT pulse cycle 0 -> load cycle 1, step_en cycles 2..17 with count 0..15, data_resultRDY cycle 18, is_div 0, data_exception 0.
REQ-033 Divide, div_zero=0: ctrl_DIV pulse cycle 0 -> step_en cycles 2..33, data_resultRDY cycle 34, is_div 1, count 32 in DONE.
REQ-034 Divide, div_zero=1: ctrl_DIV pulse cycle 0 -> data_resultRDY=1 and data_exception=1 in cycle 1 only, load and step_en never high.
REQ-035 Abort: ctrl_MULT cycle 0, ctrl_DIV cycle 10 -> no data_resultRDY at cycle 18; load cycle 11, data_resultRDY cycle 44 with is_div 1.
REQ-036 Simultaneous start: ctrl_MULT=ctrl_DIV=1 cycle 0 -> multiply sequence, data_resultRDY cycle 18, is_div 0.
REQ-037 Async reset: clr low mid-RUN at count 7 (between edges) -> all outputs 0 before next edge; no data_resultRDY after release; fresh ctrl_MULT completes per REQ-032.
